mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly downstream of the cpu's two memory request ports (IFU fetch port, LSU load/store port).
- Arbitrates them onto a single memory request port of the same req/resp protocol; that port feeds the SoC bus bridge.
- Serialises transactions: exactly one outstanding request at a time.
- Round-robin tie-break and a response watchdog, so a dead slave cannot hang the core.

Parameters:
TIMEOUT_CYCLES, 1023, cycles in BUSY without io_mem_respValid before a forced error response; 0 disables the watchdog.
TIMEOUT_RDATA, 32'hDEAD_BEEF, rdata returned to the owner on a watchdog response.

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
io_ifu_reqValid  in  1  IFU request valid
io_ifu_addr  in  32  IFU fetch address
io_ifu_respValid  out  1  IFU response pulse
io_ifu_rdata  out  32  IFU read data
io_lsu_reqValid  in  1  LSU request valid
io_lsu_addr  in  32  LSU address
io_lsu_size  in  2  LSU size (0=byte, 1=half, 2=word)
io_lsu_wen  in  1  LSU write enable
io_lsu_wdata  in  32  LSU write data
io_lsu_wmask  in  4  LSU byte mask
io_lsu_respValid  out  1  LSU response pulse
io_lsu_rdata  out  32  LSU read data
io_mem_reqValid  out  1  downstream request valid
io_mem_addr  out  32  downstream address
io_mem_size  out  2  downstream size
io_mem_wen  out  1  downstream write enable
io_mem_wdata  out  32  downstream write data
io_mem_wmask  out  4  downstream byte mask
io_mem_respValid  in  1  downstream response pulse
io_mem_rdata  in  32  downstream read data

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, owner/last_grant = IFU, timeout counter 0.
  - All io_mem_* request registers 0.
  - Both respValid outputs 0.
  - Reset asserted mid-transaction abandons it; no response is issued.
- States IDLE, BUSY.
- IDLE:
  - Evaluate requests at each rising edge.
  - Only one reqValid high: grant that port.
  - Both high: grant the port NOT equal to last_grant. After reset this means LSU first.
  - On grant:
    - Latch addr/size/wen/wdata/wmask into registers.
    - Set owner and last_grant.
    - Clear the counter and go to BUSY.
  - IFU grant forces size=2, wen=0, wdata=0, wmask=0.
- BUSY:
  - io_mem_reqValid=1; all io_mem_* fields held stable from registers.
  - Counter increments each cycle.
  - Requests from either cpu port are ignored.
- Completion:
  - The cycle io_mem_respValid=1 in BUSY, owner respValid=1 combinationally (zero added latency) and owner rdata=io_mem_rdata.
  - At the next edge: state→IDLE, io_mem_reqValid→0.
  - Non-owner respValid stays 0.
  - Both rdata outputs mirror io_mem_rdata whenever no watchdog response is active.
- Latency:
  - Grant edge N → io_mem_reqValid high in cycle N+1.
  - Minimum gap between consecutive downstream requests is one IDLE cycle.
- Requester rule: reqValid must be low at the edge following its respValid pulse. The arbiter re-samples only from that edge on, so no duplicate grant is possible.
- Watchdog (TIMEOUT_CYCLES>0):
  - If the counter reaches TIMEOUT_CYCLES with no io_mem_respValid, owner respValid pulses one cycle with rdata=TIMEOUT_RDATA.
  - io_mem_reqValid drops at the next edge; state→IDLE.
  - If io_mem_respValid arrives in the same cycle as the timeout, the real response wins.
- io_mem_respValid while IDLE (late or stray) is ignored; neither respValid asserts.
- Counter is 32 bits and saturates; it never wraps into a false timeout.

Decomposition:
- Shared package `mem_pkg`:
  - typedef mem_req_t struct (addr, size, wen, wdata, wmask).
  - enum arb_state_e {IDLE, BUSY}.
  - enum port_e {PORT_IFU, PORT_LSU}.
  - Size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- Single module, no sub-modules; the round-robin pick is a small function inside the package.

Test Plan:
- LSU-only store addr=0x8000_0010, wdata=0x1234_5678, wmask=4'b0011, size=1; mem responds 3 cycles later → io_mem_* match the LSU fields from cycle N+1; io_lsu_respValid pulses exactly 1 cycle, coincident with io_mem_respValid; IFU sees no pulse.
- IFU-only fetch addr=0x3000_0000; mem rdata=0x0000_0013 → io_mem_size=2, io_mem_wen=0, io_mem_wmask=0; io_ifu_rdata=0x13 with respValid.
- Both request in the same cycle after reset → LSU served first. IFU stays pending and is granted one IDLE cycle after the LSU response. Repeat the tie → IFU now wins (alternation).
- Mem never responds, TIMEOUT_CYCLES=8 → owner respValid pulses in the 8th BUSY cycle with rdata=0xDEAD_BEEF; a later stray io_mem_respValid in IDLE produces no pulse.
- Reset deasserted→asserted while BUSY → io_mem_reqValid=0 immediately (asynchronous), no respValid. After release, a new LSU request is granted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and round-robin pick for the cpu memory arbiter
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_IFU = 1'b0,
        PORT_LSU = 1'b1
    } port_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    // A sole requester wins; on a tie the port that did not win last time goes.
    function automatic port_e rr_pick(input logic ifu_req, input logic lsu_req, input port_e last);
        port_e pick;
        if (ifu_req && lsu_req) begin
            pick = (last == PORT_IFU) ? PORT_LSU : PORT_IFU;
        end else if (lsu_req) begin
            pick = PORT_LSU;
        end else begin
            pick = PORT_IFU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises IFU and LSU requests onto one memory port with a response watchdog
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ifu_reqValid,
    input  logic [31:0] io_ifu_addr,
    output logic        io_ifu_respValid,
    output logic [31:0] io_ifu_rdata,
    input  logic        io_lsu_reqValid,
    input  logic [31:0] io_lsu_addr,
    input  logic [1:0]  io_lsu_size,
    input  logic        io_lsu_wen,
    input  logic [31:0] io_lsu_wdata,
    input  logic [3:0]  io_lsu_wmask,
    output logic        io_lsu_respValid,
    output logic [31:0] io_lsu_rdata,
    output logic        io_mem_reqValid,
    output logic [31:0] io_mem_addr,
    output logic [1:0]  io_mem_size,
    output logic        io_mem_wen,
    output logic [31:0] io_mem_wdata,
    output logic [3:0]  io_mem_wmask,
    input  logic        io_mem_respValid,
    input  logic [31:0] io_mem_rdata
);

    localparam bit          LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);
    // The counter reads 0 in the first BUSY cycle, so cycle N of BUSY sees N-1.
    localparam logic [31:0] LP_WDOG_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    arb_state_e  r_state;
    arb_state_e  w_state_next;
    port_e       r_owner;
    port_e       r_last_grant;
    port_e       w_pick;
    mem_req_t    r_req;
    mem_req_t    w_grant_req;
    logic        r_mem_req_valid;
    logic [31:0] r_count;

    logic        w_grant;
    logic        w_resp_real;
    logic        w_timeout;
    logic        w_done;
    logic        w_ifu_owns;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_resp_real  = 1'b0;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_ifu_reqValid || io_lsu_reqValid) begin
                    w_grant      = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_resp_real = io_mem_respValid;
                // A real response arriving on the deadline cycle takes priority.
                w_timeout   = LP_WDOG_EN && !io_mem_respValid && (r_count >= LP_WDOG_LAST);
                w_done      = w_resp_real || w_timeout;
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_pick = rr_pick(io_ifu_reqValid, io_lsu_reqValid, r_last_grant);

    always_comb begin
        w_grant_req = '0;
        if (w_pick == PORT_LSU) begin
            w_grant_req.addr  = io_lsu_addr;
            w_grant_req.size  = io_lsu_size;
            w_grant_req.wen   = io_lsu_wen;
            w_grant_req.wdata = io_lsu_wdata;
            w_grant_req.wmask = io_lsu_wmask;
        end else begin
            w_grant_req.addr  = io_ifu_addr;
            w_grant_req.size  = SZ_WORD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_req           <= '0;
            r_mem_req_valid <= 1'b0;
            r_owner         <= PORT_IFU;
            r_last_grant    <= PORT_IFU;
            r_count         <= 32'd0;
        end else if (w_grant) begin
            r_req           <= w_grant_req;
            r_mem_req_valid <= 1'b1;
            r_owner         <= w_pick;
            r_last_grant    <= w_pick;
            r_count         <= 32'd0;
        end else if (w_done) begin
            r_mem_req_valid <= 1'b0;
        end else if ((r_state == BUSY) && (r_count != 32'hFFFF_FFFF)) begin
            r_count         <= r_count + 32'd1;
        end
    end

    assign io_mem_reqValid  = r_mem_req_valid;
    assign io_mem_addr      = r_req.addr;
    assign io_mem_size      = r_req.size;
    assign io_mem_wen       = r_req.wen;
    assign io_mem_wdata     = r_req.wdata;
    assign io_mem_wmask     = r_req.wmask;

    assign w_ifu_owns       = (r_owner == PORT_IFU);
    assign io_ifu_respValid = w_done && w_ifu_owns;
    assign io_lsu_respValid = w_done && !w_ifu_owns;
    assign io_ifu_rdata     = (w_timeout && w_ifu_owns)  ? TIMEOUT_RDATA : io_mem_rdata;
    assign io_lsu_rdata     = (w_timeout && !w_ifu_owns) ? TIMEOUT_RDATA : io_mem_rdata;

endmodule
